dut_launcher: RTL and testbench
===============================

// Module: dut_launcher
// PURPOSE
//  Host-side initiator for the 9-bit-ISA core's init/req/ack program handshake. It is the other end of that handshake.
//  Per run: holds the core in init, preloads DUT data memory, pulses req, then counts cycles until ack or timeout.
//  After that it copies the result window of data memory into a capture buffer.
//  Sits between the test-vector source and top_level in the bench/SoC wrapper.
// PARAMETERS
//  INIT_CYCLES  4    cycles dut_init is held high (>=1)
//  LOAD_BASE    0    first DUT mem address written during preload (8b)
//  LOAD_LEN     64   bytes preloaded (1..256-LOAD_BASE)
//  RES_BASE     64   first DUT mem address read back (8b)
//  RES_LEN      64   bytes read back (1..256-RES_BASE)
//  CW           16   width of cycle counter / timeout
//  TIMEOUT      4000 max cycles from req to ack before abort
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  init_n     in   1   asynchronous active-low reset
//  start      in   1   launch a run; sampled only in IDLE
//  src_addr   out  8   preload source index (0..LOAD_LEN-1)
//  src_data   in   8   preload byte, combinational from src_addr
//  dut_init   out  1   to top_level.init (active-high core reset)
//  dut_req    out  1   to top_level.req
//  dut_ack    in   1   from top_level.ack (level, done flag)
//  mem_we     out  1   DUT data-memory backdoor write enable
//  mem_addr   out  8   backdoor address
//  mem_wdata  out  8   backdoor write data
//  mem_rdata  in   8   backdoor read data, combinational from mem_addr
//  res_we     out  1   capture-buffer write strobe
//  res_addr   out  8   capture index (0..RES_LEN-1)
//  res_data   out  8   captured byte
//  busy       out  1   high in every state except IDLE/DONE
//  done       out  1   high in DONE until next accepted start
//  timed_out  out  1   sticky with done: run aborted on TIMEOUT
//  cycles     out  CW  req-to-ack latency of last run, saturating
// BEHAVIOUR
//  Reset (init_n=0, async): state=IDLE; all outputs 0; counters 0.
//  FSM: IDLE->RESET->LOAD->START->WAIT->UNLOAD->DONE; DONE->RESET on start.
//  IDLE: on start=1 go RESET. Clear done, timed_out and cycles on that same edge.
//  RESET: dut_init=1 for exactly INIT_CYCLES cycles, then LOAD. dut_init=0 in every other state.
//  LOAD: one byte per cycle, index i=0..LOAD_LEN-1.
//    mem_we=1, mem_addr=LOAD_BASE+i, mem_wdata=src_data, src_addr=i.
//    After the last byte go START. Backdoor is only driven while dut_init=1 or req=0.
//  START: dut_req=1 for exactly 1 cycle; cycle counter loads 1; go WAIT.
//  WAIT: counter += 1 per cycle; dut_req=0.
//    On dut_ack=1: cycles<=counter, go UNLOAD. Ack is sampled, not edge-detected.
//    If counter reaches TIMEOUT with no ack: cycles<=TIMEOUT, timed_out<=1, go DONE and skip UNLOAD.
//    An ack and the timeout in the same cycle count as ack.
//  UNLOAD: mem_addr=RES_BASE+j, res_we=1, res_addr=j, res_data=mem_rdata for j=0..RES_LEN-1.
//    After the last byte go DONE.
//  DONE: done=1, busy=0. start relaunches and clears done/timed_out. dut_ack may remain high.
//  Counter saturates at 2^CW-1 and never wraps. Address math is mod 256; params must not wrap.
//  start outside IDLE/DONE is ignored. A start held high relaunches once per DONE visit.
//  init_n low mid-run: immediate IDLE, dut_init=0, dut_req=0, no partial strobes.
// STRUCTURE
//  Package Definitions: typedef enum logic[2:0] launch_state_t
//    {L_IDLE,L_RESET,L_LOAD,L_START,L_WAIT,L_UNLOAD,L_DONE}.
//  Sub-module launch_counter: CW-bit counter with clear, load-1, saturate and terminal-match output.
//    Reused for the init hold, load index, unload index and WAIT latency.
//  Remaining outputs are decoded from state plus index; all registered outputs reset to 0.
// TESTING
//  1 Reset: init_n=0 mid-WAIT -> next edge all outputs 0, state IDLE. dut_ack=1 while init_n=0 has no effect.
//  2 Nominal: LOAD_LEN=4, src bytes 11,22,33,44; model ack 10 cycles after req.
//    Expect: dut_init high 4 cycles; mem writes at 0..3 = 11,22,33,44; req 1 cycle; cycles=10.
//    Then RES_LEN res_we strobes match the model mem; done=1.
//  3 Timeout: TIMEOUT=20, ack held 0 -> done=1, timed_out=1, cycles=20, res_we never asserted.
//  4 Ack and timeout same cycle: ack at count 20 with TIMEOUT=20 -> timed_out=0, UNLOAD runs.
//  5 Relaunch: start held high through DONE -> second run begins; done/timed_out clear on accept.
//    The stale ack from run 1 does not end run 2 early, because dut_init resets the core's ack.
//  6 Saturation: CW=4, TIMEOUT=15, ack at 14 -> cycles=14; with TIMEOUT above 15, cycles sticks at 15 and never wraps.

Source files
------------

// File: rtl/dut_launcher_pkg.sv
// Shared types and helpers for the program-handshake launcher.
package dut_launcher_pkg;

    typedef enum logic [2:0] {
        L_IDLE,
        L_RESET,
        L_LOAD,
        L_START,
        L_WAIT,
        L_UNLOAD,
        L_DONE
    } launch_state_t;

    // Index counter width: covers byte indices 0..255 and init holds up to 256 cycles.
    localparam int IDX_W = 8;

    function automatic logic is_busy(input launch_state_t s);
        return (s != L_IDLE) && (s != L_DONE);
    endfunction

endpackage

// File: rtl/dut_launcher_counter.sv
// Saturating up-counter with clear, load-one and terminal-match flag.
module launch_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         ld1_i,
    input  logic         inc_i,
    input  logic [W-1:0] match_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (ld1_i)
            cnt_d = W'(1);
        else if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == match_i);

endmodule

// File: rtl/dut_launcher.sv
// Host-side initiator for the core's init/req/ack handshake: reset, preload,
// launch, time the run and copy the result window into a capture buffer.
//   state    | meaning
//   L_IDLE   | waiting for start after reset
//   L_RESET  | core held in init for INIT_CYCLES cycles
//   L_LOAD   | one preload byte written per cycle
//   L_START  | single-cycle req pulse, latency counter loads 1
//   L_WAIT   | counting until ack or timeout
//   L_UNLOAD | one result byte captured per cycle
//   L_DONE   | run finished, results stable until next start
module dut_launcher
    import dut_launcher_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int LOAD_BASE   = 0,
    parameter int LOAD_LEN    = 64,
    parameter int RES_BASE    = 64,
    parameter int RES_LEN     = 64,
    parameter int CW          = 16,
    parameter int TIMEOUT     = 4000
) (
    input  logic          clk_i,
    input  logic          init_n_i,
    input  logic          start_i,
    output logic [7:0]    src_addr_o,
    input  logic [7:0]    src_data_i,
    output logic          dut_init_o,
    output logic          dut_req_o,
    input  logic          dut_ack_i,
    output logic          mem_we_o,
    output logic [7:0]    mem_addr_o,
    output logic [7:0]    mem_wdata_o,
    input  logic [7:0]    mem_rdata_i,
    output logic          res_we_o,
    output logic [7:0]    res_addr_o,
    output logic [7:0]    res_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          timed_out_o,
    output logic [CW-1:0] cycles_o
);

    // A timeout beyond the counter's reach can never fire; the counter just saturates.
    localparam bit TO_REACH = (TIMEOUT <= (2 ** CW) - 1);
    localparam logic [CW-1:0] TO_MATCH = TO_REACH ? CW'(TIMEOUT) : '0;

    launch_state_t   state_q;
    logic            timed_out_q;
    logic [CW-1:0]   cycles_q;

    logic [IDX_W-1:0] idx_cnt, idx_match;
    logic             idx_tc, idx_inc;
    logic [CW-1:0]    lat_cnt;
    logic             lat_tc, to_hit;

    always_comb begin
        idx_match = '0;
        case (state_q)
            L_RESET:  idx_match = IDX_W'(INIT_CYCLES - 1);
            L_LOAD:   idx_match = IDX_W'(LOAD_LEN - 1);
            L_UNLOAD: idx_match = IDX_W'(RES_LEN - 1);
            default:  idx_match = '0;
        endcase
    end

    assign idx_inc = ((state_q == L_RESET) || (state_q == L_LOAD) || (state_q == L_UNLOAD))
                     && !idx_tc;

    launch_counter #(.W(IDX_W)) u_idx (
        .clk_i   (clk_i),
        .rst_n_i (init_n_i),
        .clr_i   (!idx_inc),
        .ld1_i   (1'b0),
        .inc_i   (idx_inc),
        .match_i (idx_match),
        .cnt_o   (idx_cnt),
        .tc_o    (idx_tc)
    );

    launch_counter #(.W(CW)) u_lat (
        .clk_i   (clk_i),
        .rst_n_i (init_n_i),
        .clr_i   (state_q == L_IDLE),
        .ld1_i   (state_q == L_START),
        .inc_i   (state_q == L_WAIT),
        .match_i (TO_MATCH),
        .cnt_o   (lat_cnt),
        .tc_o    (lat_tc)
    );

    assign to_hit = TO_REACH && lat_tc;

    always_ff @(posedge clk_i or negedge init_n_i) begin
        if (!init_n_i) begin
            state_q     <= L_IDLE;
            timed_out_q <= 1'b0;
            cycles_q    <= '0;
        end else begin
            case (state_q)
                L_IDLE, L_DONE: begin
                    if (start_i) begin
                        state_q     <= L_RESET;
                        timed_out_q <= 1'b0;
                        cycles_q    <= '0;
                    end
                end
                L_RESET:  if (idx_tc) state_q <= L_LOAD;
                L_LOAD:   if (idx_tc) state_q <= L_START;
                L_START:  state_q <= L_WAIT;
                L_WAIT: begin
                    // Ack wins over a timeout landing on the same cycle.
                    if (dut_ack_i) begin
                        cycles_q <= lat_cnt;
                        state_q  <= L_UNLOAD;
                    end else if (to_hit) begin
                        cycles_q    <= TO_MATCH;
                        timed_out_q <= 1'b1;
                        state_q     <= L_DONE;
                    end
                end
                L_UNLOAD: if (idx_tc) state_q <= L_DONE;
                default:  state_q <= L_IDLE;
            endcase
        end
    end

    always_comb begin
        src_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        res_we_o    = 1'b0;
        res_addr_o  = '0;
        res_data_o  = '0;
        if (state_q == L_LOAD) begin
            src_addr_o  = idx_cnt;
            mem_we_o    = 1'b1;
            mem_addr_o  = 8'(LOAD_BASE) + idx_cnt;
            mem_wdata_o = src_data_i;
        end else if (state_q == L_UNLOAD) begin
            mem_addr_o = 8'(RES_BASE) + idx_cnt;
            res_we_o   = 1'b1;
            res_addr_o = idx_cnt;
            res_data_o = mem_rdata_i;
        end
    end

    assign dut_init_o  = (state_q == L_RESET);
    assign dut_req_o   = (state_q == L_START);
    assign busy_o      = is_busy(state_q);
    assign done_o      = (state_q == L_DONE);
    assign timed_out_o = timed_out_q;
    assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_dut_launcher.sv
// Directed bench for dut_launcher: a 16-bit-counter instance for the run flow
// and a 4-bit-counter instance for latency saturation.
module tb_dut_launcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic init_n;
    logic start_a, start_b;

    logic [7:0]  src_addr_a, src_data_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
    logic [7:0]  res_addr_a, res_data_a;
    logic        dut_init_a, dut_req_a, mem_we_a, res_we_a, busy_a, done_a, to_a;
    logic        ack_a = 1'b0;
    logic [15:0] cycles_a;

    logic [7:0]  src_addr_b, src_data_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic [7:0]  res_addr_b, res_data_b;
    logic        dut_init_b, dut_req_b, mem_we_b, res_we_b, busy_b, done_b, to_b;
    logic        ack_b = 1'b0;
    logic [3:0]  cycles_b;

    dut_launcher #(.INIT_CYCLES(4), .LOAD_BASE(0), .LOAD_LEN(4), .RES_BASE(64),
                   .RES_LEN(4), .CW(16), .TIMEOUT(20)) u_a (
        .clk_i(clk), .init_n_i(init_n), .start_i(start_a),
        .src_addr_o(src_addr_a), .src_data_i(src_data_a),
        .dut_init_o(dut_init_a), .dut_req_o(dut_req_a), .dut_ack_i(ack_a),
        .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a),
        .mem_rdata_i(mem_rdata_a),
        .res_we_o(res_we_a), .res_addr_o(res_addr_a), .res_data_o(res_data_a),
        .busy_o(busy_a), .done_o(done_a), .timed_out_o(to_a), .cycles_o(cycles_a)
    );

    dut_launcher #(.INIT_CYCLES(2), .LOAD_BASE(0), .LOAD_LEN(2), .RES_BASE(64),
                   .RES_LEN(2), .CW(4), .TIMEOUT(20)) u_b (
        .clk_i(clk), .init_n_i(init_n), .start_i(start_b),
        .src_addr_o(src_addr_b), .src_data_i(src_data_b),
        .dut_init_o(dut_init_b), .dut_req_o(dut_req_b), .dut_ack_i(ack_b),
        .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
        .mem_rdata_i(mem_rdata_b),
        .res_we_o(res_we_b), .res_addr_o(res_addr_b), .res_data_o(res_data_b),
        .busy_o(busy_b), .done_o(done_b), .timed_out_o(to_b), .cycles_o(cycles_b)
    );

    // Source ROM and memory models
    always_comb begin
        case (src_addr_a)
            8'd0:    src_data_a = 8'h11;
            8'd1:    src_data_a = 8'h22;
            8'd2:    src_data_a = 8'h33;
            8'd3:    src_data_a = 8'h44;
            default: src_data_a = 8'h00;
        endcase
    end
    assign src_data_b  = src_addr_b + 8'h80;
    assign mem_rdata_b = mem_addr_b ^ 8'h5A;

    bit [7:0] mem_a [256];
    bit       wr_a  [256];
    bit [7:0] cap_a [256];
    assign mem_rdata_a = wr_a[mem_addr_a] ? mem_a[mem_addr_a] : (mem_addr_a ^ 8'hC3);

    int n_init_a = 0, n_req_a = 0, n_wr_a = 0, n_res_a = 0, n_res_b = 0;

    always @(posedge clk) begin
        if (dut_init_a) n_init_a <= n_init_a + 1;
        if (dut_req_a)  n_req_a  <= n_req_a + 1;
        if (mem_we_a) begin
            mem_a[mem_addr_a] <= mem_wdata_a;
            wr_a[mem_addr_a]  <= 1'b1;
            n_wr_a            <= n_wr_a + 1;
        end
        if (res_we_a) begin
            cap_a[res_addr_a] <= res_data_a;
            n_res_a           <= n_res_a + 1;
        end
        if (res_we_b) n_res_b <= n_res_b + 1;
    end

    // Core models: ack rises ack_delay cycles after req, held until the next init.
    int ack_delay_a = 0, ack_delay_b = 0;
    int cnt_a = 0, cnt_b = 0;
    bit seen_a = 1'b0, seen_b = 1'b0;

    always @(posedge clk) begin
        if (dut_init_a) begin
            seen_a <= 1'b0; ack_a <= 1'b0; cnt_a <= 0;
        end else if (dut_req_a) begin
            seen_a <= 1'b1; cnt_a <= 1; ack_a <= (ack_delay_a == 1);
        end else if (seen_a) begin
            cnt_a <= cnt_a + 1;
            if (ack_delay_a != 0 && cnt_a + 1 == ack_delay_a) ack_a <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (dut_init_b) begin
            seen_b <= 1'b0; ack_b <= 1'b0; cnt_b <= 0;
        end else if (dut_req_b) begin
            seen_b <= 1'b1; cnt_b <= 1; ack_b <= (ack_delay_b == 1);
        end else if (seen_b) begin
            cnt_b <= cnt_b + 1;
            if (ack_delay_b != 0 && cnt_b + 1 == ack_delay_b) ack_b <= 1'b1;
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic wait_done_a(input string tag);
        int n = 0;
        while (!done_a && n < 500) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_done"}, 32'(done_a), 1);
    endtask

    task automatic wait_done_b(input string tag);
        int n = 0;
        while (!done_b && n < 500) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_done"}, 32'(done_b), 1);
    endtask

    initial begin
        int s_init, s_req, s_wr, s_res;
        logic [7:0] exp_b;
        logic [7:0] src_exp [4];
        int n;

        src_exp[0] = 8'h11; src_exp[1] = 8'h22; src_exp[2] = 8'h33; src_exp[3] = 8'h44;
        init_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",   32'(busy_a), 0);
        check("rst_done",   32'(done_a), 0);
        check("rst_init",   32'(dut_init_a), 0);
        check("rst_cycles", 32'(cycles_a), 0);
        init_n = 1'b1;
        @(posedge clk); #1;

        // Nominal run: ack 10 cycles after req
        ack_delay_a = 10;
        s_init = n_init_a; s_req = n_req_a; s_wr = n_wr_a; s_res = n_res_a;
        start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
        check("nom_busy", 32'(busy_a), 1);
        wait_done_a("nom");
        check("nom_init_len", 32'(n_init_a - s_init), 4);
        check("nom_writes",   32'(n_wr_a - s_wr), 4);
        check("nom_req_len",  32'(n_req_a - s_req), 1);
        for (int i = 0; i < 4; i++)
            check($sformatf("nom_mem%0d", i), 32'(mem_a[i]), 32'(src_exp[i]));
        check("nom_cycles", 32'(cycles_a), 10);
        check("nom_to",     32'(to_a), 0);
        check("nom_busy_done", 32'(busy_a), 0);
        check("nom_res_cnt", 32'(n_res_a - s_res), 4);
        for (int j = 0; j < 4; j++) begin
            exp_b = 8'(64 + j);
            exp_b = exp_b ^ 8'hC3;
            check($sformatf("nom_cap%0d", j), 32'(cap_a[j]), 32'(exp_b));
        end

        // Timeout: no ack
        ack_delay_a = 0;
        s_res = n_res_a;
        start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
        wait_done_a("tmo");
        check("tmo_to",      32'(to_a), 1);
        check("tmo_cycles",  32'(cycles_a), 20);
        check("tmo_res_cnt", 32'(n_res_a - s_res), 0);

        // Relaunch with start held high through DONE
        ack_delay_a = 7;
        start_a = 1'b1;
        @(posedge clk); #1;
        check("rel1_to_clr",   32'(to_a), 0);
        check("rel1_done_clr", 32'(done_a), 0);
        check("rel1_cyc_clr",  32'(cycles_a), 0);
        check("rel1_init",     32'(dut_init_a), 1);
        wait_done_a("rel1");
        check("rel1_cycles", 32'(cycles_a), 7);
        check("rel1_stale_ack", 32'(ack_a), 1);

        // Second relaunch from the same held start; stale ack must not end it,
        // and an ack landing on the timeout cycle counts as ack.
        ack_delay_a = 20;
        s_res = n_res_a;
        @(posedge clk); #1;
        check("rel2_busy", 32'(busy_a), 1);
        start_a = 1'b0;
        wait_done_a("same");
        check("same_cycles",  32'(cycles_a), 20);
        check("same_to",      32'(to_a), 0);
        check("same_res_cnt", 32'(n_res_a - s_res), 4);

        // Async reset in the middle of WAIT, ack rising during reset
        ack_delay_a = 3;
        start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
        n = 0;
        while (!dut_req_a && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("mid_req_seen", 32'(dut_req_a), 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        init_n = 1'b0;
        #1;
        check("mid_busy", 32'(busy_a), 0);
        check("mid_req",  32'(dut_req_a), 0);
        check("mid_init", 32'(dut_init_a), 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("mid_ack_high", 32'(ack_a), 1);
        check("mid_busy2",  32'(busy_a), 0);
        check("mid_mem_we", 32'(mem_we_a), 0);
        check("mid_res_we", 32'(res_we_a), 0);
        check("mid_done",   32'(done_a), 0);
        init_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("post_busy", 32'(busy_a), 0);
        check("post_done", 32'(done_a), 0);

        // Narrow counter: unsaturated latency, then saturation at 15
        ack_delay_b = 14;
        s_res = n_res_b;
        start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
        wait_done_b("sat14");
        check("sat14_cycles", 32'(cycles_b), 14);
        check("sat14_to",     32'(to_b), 0);
        check("sat14_res",    32'(n_res_b - s_res), 2);

        ack_delay_b = 25;
        start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
        wait_done_b("sat25");
        check("sat25_cycles", 32'(cycles_b), 15);
        check("sat25_to",     32'(to_b), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
